seq_multiplier: RTL and testbench
=================================

Name: seq_multiplier

Overview:
Parametrised shift-add multiplier. It is the multi-cycle successor to the team's combinational 10x6 multiplier. It takes an A_W-bit and a B_W-bit unsigned operand and returns the full-width A_W+B_W-bit product after B_W iteration cycles, using a start/busy/done handshake. It sits on the datapath wherever area matters more than latency, such as the ALU multiply path.

Parameters:
A_W, 10, multiplicand (in1) width; minimum 2
B_W, 6, multiplier (in2) width; minimum 2; sets the iteration count
P_W, A_W+B_W, product width; derived, not to be overridden

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
in1  input  A_W  multiplicand; captured on the accepting edge
in2  input  B_W  multiplier; captured on the accepting edge
busy  output  1  high in CALC and DONE
done  output  1  one-cycle pulse when out becomes valid
out  output  P_W  product; held stable until the next accepted start

Behaviour:
- Reset: reset_n low asynchronously forces the following:
  - state=IDLE, busy=0, done=0, out=0.
  - Internal accumulator, operand registers and counter are cleared.
- Reset mid-operation aborts the operation. No done pulse is produced and out reads 0.
- FSM states are IDLE, CALC and DONE.
- IDLE:
  - On an edge with start=1: latch in1 and in2, clear the accumulator, set count=0, go to CALC. busy=1 from that edge.
  - With start=0: stay in IDLE; out keeps its last value.
- CALC: one multiplier bit per edge, LSB first.
  - If the current multiplier bit is 1, add the multiplicand into the upper A_W+1 bits of the accumulator.
  - Then shift the accumulator/multiplier pair right by 1. The carry is preserved, so no overflow loss occurs.
  - count increments each edge. After the B_W-th CALC edge: out=product, done=1, go to DONE.
- DONE: lasts one cycle; done=1, busy=1. The next edge goes to IDLE with done=0 and busy=0.
- Latency and throughput:
  - done is high on the cycle following the (B_W+1)-th edge after the accepting edge.
  - Minimum start-to-start spacing is B_W+2 cycles.
- start asserted in CALC or DONE is ignored. It is not queued, and in1/in2 changes in those states have no effect.
- out is exact for all inputs; the maximum product (2^A_W-1)(2^B_W-1) always fits in P_W.
- Zero operands still take the full B_W cycles; there is no early termination.
- Counter width is clog2(B_W+1). No wrap-around is possible because the FSM exits at count==B_W.

Optional Feature:
Macro: SEQ_MULT_SIGNED_EN
- Defined:
  - Adds input port signed_mode (1 bit), sampled with start and held internally for the operation.
  - When signed_mode=1, in1 and in2 are two's complement. The multiplicand is sign-extended into the adder. The right shift is arithmetic. On the final CALC step (multiplier MSB) the multiplicand is subtracted instead of added.
  - out is the signed P_W-bit product. The result is exact, including -2^(A_W-1) x -2^(B_W-1).
  - When signed_mode=0, behaviour is identical to the unsigned build.
- Not defined: no signed_mode port; unsigned only. Timing is identical in both builds.

Test Plan:
- Reset with reset_n=0 then 1; no start -> out=16'h0000, busy=0, done=0.
- Default params; start with in1=10'h3ff, in2=6'h3f -> done pulses exactly 7 edges after the accepting edge, out=16'hFBC1. Repeat with 10'h3f x 6'h1f -> 16'h07A1; 10'h3ff x 6'h30 -> 16'hBFD0; 10'h3de x 6'h3f -> 16'hF3A2; 0 x 0 -> 16'h0000.
- Start with 10'h3ff x 6'h3f. Pulse start again with new operands 3 cycles later -> ignored; out=16'hFBC1; only one done pulse. Next start issued in IDLE is accepted normally.
- Start with 10'h3ff x 6'h3f; drop reset_n for 1 cycle during CALC -> no done pulse, out=0, busy=0. A subsequent start with 10'h3f x 6'h1f -> 16'h07A1.
- Params A_W=8, B_W=8 with 8'hff x 8'hff -> out=16'hFE01 after 9 edges. Back-to-back starts issued at minimum spacing (10 cycles) -> every request is accepted.
- SEQ_MULT_SIGNED_EN defined, signed_mode=1:
  - 10'h3ff x 6'h3f (-1 x -1) -> 16'h0001.
  - 10'h200 x 6'h20 (-512 x -32) -> 16'h4000.
  - 10'h005 x 6'h3e (5 x -2) -> 16'hFFF6.
  - With signed_mode=0: 10'h3ff x 6'h3f -> 16'hFBC1.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-add multiplier, one multiplier bit per clock.
// An A_W x B_W unsigned product is ready B_W cycles after the accepting edge,
// using a start / busy / done handshake.
// Optional build macro SEQ_MULT_SIGNED_EN adds a signed_mode input that selects
// two's complement operands for one operation.
module seq_multiplier #(
    parameter int A_W = 10,
    parameter int B_W = 6,
    parameter int P_W = A_W + B_W
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
`ifdef SEQ_MULT_SIGNED_EN
    input  logic           signed_mode,
`endif
    input  logic [A_W-1:0] in1,
    input  logic [B_W-1:0] in2,
    output logic           busy,
    output logic           done,
    output logic [P_W-1:0] out
);

    localparam int CNT_W = $clog2(B_W + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       r_state;
    logic [A_W-1:0]   r_mcand;   // latched multiplicand
    logic [B_W-1:0]   r_mplier;  // multiplier, shares the right shift with r_acc
    logic [A_W:0]     r_acc;     // upper A_W+1 accumulator bits (keeps the carry)
    logic [CNT_W-1:0] r_cnt;
    logic [P_W-1:0]   r_out;

    logic             w_signed;
    logic             w_last;
    logic             w_sub;
    logic [A_W:0]     w_addend;
    logic [A_W:0]     w_sum;

`ifdef SEQ_MULT_SIGNED_EN
    logic r_signed;
    assign w_signed = r_signed;
`else
    assign w_signed = 1'b0;
`endif

    // The B_W-th CALC step handles the multiplier MSB; in signed mode that bit
    // carries negative weight, so its partial product is subtracted.
    assign w_last = (r_cnt == CNT_W'(B_W - 1));
    assign w_sub  = w_signed & w_last;

    // Partial product: multiplicand (sign-extended in signed mode) gated by the current multiplier bit.
    always_comb begin
        w_addend = '0;
        if (r_mplier[0]) begin
            w_addend = {w_signed & r_mcand[A_W-1], r_mcand};
        end
        w_sum = w_sub ? (r_acc - w_addend) : (r_acc + w_addend);
    end

    // Control FSM: IDLE accepts start, CALC runs B_W steps, DONE lasts one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (start) r_state <= S_CALC;
                S_CALC:  if (w_last) r_state <= S_DONE;
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath: latch operands on accept, then add-and-shift once per CALC cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            r_signed <= 1'b0;
`endif
        end else if (r_state == S_IDLE && start) begin
            r_mcand  <= in1;
            r_mplier <= in2;
            r_acc    <= '0;
            r_cnt    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            r_signed <= signed_mode;
`endif
        end else if (r_state == S_CALC) begin
            // Shift right by one; the fill bit is the sum's sign only in signed mode.
            r_acc    <= {w_signed & w_sum[A_W], w_sum[A_W:1]};
            r_mplier <= {w_sum[0], r_mplier[B_W-1:1]};
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    // Result register: loaded from the final step, held until the next operation completes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= '0;
        end else if (r_state == S_CALC && w_last) begin
            r_out <= {w_sum, r_mplier[B_W-1:1]};
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign out  = r_out;

endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: table vectors, hand-written corner sequences and random
// operands checked against an arithmetic product model, for the default
// 10x6 configuration and an 8x8 instance.
module tb_seq_multiplier;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        start;
    logic [9:0]  in1;
    logic [5:0]  in2;
    logic        busy, done;
    logic [15:0] out;

    logic        s8_start;
    logic [7:0]  s8_in1, s8_in2;
    logic        s8_busy, s8_done;
    logic [15:0] s8_out;

`ifdef SEQ_MULT_SIGNED_EN
    logic signed_mode;
    logic s8_signed_mode;
`endif

    seq_multiplier dut (
        .clk(clk), .reset_n(reset_n), .start(start),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode(signed_mode),
`endif
        .in1(in1), .in2(in2), .busy(busy), .done(done), .out(out)
    );

    seq_multiplier #(.A_W(8), .B_W(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(s8_start),
`ifdef SEQ_MULT_SIGNED_EN
        .signed_mode(s8_signed_mode),
`endif
        .in1(s8_in1), .in2(s8_in2), .busy(s8_busy), .done(s8_done), .out(s8_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [9:0]  a;
        logic [5:0]  b;
        logic        sm;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mkvec(input logic [9:0] a, input logic [5:0] b,
                                   input logic sm, input logic [15:0] exp);
        vec_t v;
        v.a = a; v.b = b; v.sm = sm; v.exp = exp;
        return v;
    endfunction

    // Reference: plain integer product, operands reinterpreted as signed when asked.
    function automatic logic [15:0] model(input logic [9:0] a, input logic [5:0] b, input logic sm);
        int ia, ib;
        ia = int'(a);
        ib = int'(b);
        if (sm) begin
            if (a[9]) ia = ia - 1024;
            if (b[5]) ib = ib - 64;
        end
        return 16'(ia * ib);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One operation on the 10x6 instance: latency, result and end-of-op handshake.
    task automatic run_op(input logic [9:0] a, input logic [5:0] b, input logic sm,
                          input string name, input logic [15:0] exp);
        int n;
        string tag;
        tag = $sformatf("%s(sm=%0d)", name, sm);
        @(negedge clk);
        start = 1'b1; in1 = a; in2 = b;
`ifdef SEQ_MULT_SIGNED_EN
        signed_mode = sm;
`endif
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        in1 = 10'($urandom);
        in2 = 6'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
        signed_mode = ~sm;
`endif
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        // Edges counted including the accepting one: B_W+1 = 7.
        check({tag, "_latency"}, n + 1, 7);
        check({tag, "_out"}, {16'd0, out}, {16'd0, exp});
        @(negedge clk);
        check({tag, "_end_done_busy"}, {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int dones, n;
        logic [9:0]  ra;
        logic [5:0]  rb;
        logic        rsm;
        logic [7:0]  a8, b8;
        logic [15:0] e8;

        reset_n = 1'b0; start = 1'b0; in1 = '0; in2 = '0;
        s8_start = 1'b0; s8_in1 = '0; s8_in2 = '0;
`ifdef SEQ_MULT_SIGNED_EN
        signed_mode = 1'b0; s8_signed_mode = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("reset_out", {16'd0, out}, 32'h0);
        check("reset_busy_done", {30'd0, busy, done}, 32'h0);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_start", {14'd0, busy, done, out}, 32'h0);

        vecs.push_back(mkvec(10'h3ff, 6'h3f, 1'b0, 16'hFBC1));
        vecs.push_back(mkvec(10'h03f, 6'h1f, 1'b0, 16'h07A1));
        vecs.push_back(mkvec(10'h3ff, 6'h30, 1'b0, 16'hBFD0));
        vecs.push_back(mkvec(10'h3de, 6'h3f, 1'b0, 16'hF3A2));
        vecs.push_back(mkvec(10'h000, 6'h00, 1'b0, 16'h0000));
`ifdef SEQ_MULT_SIGNED_EN
        vecs.push_back(mkvec(10'h3ff, 6'h3f, 1'b1, 16'h0001));
        vecs.push_back(mkvec(10'h200, 6'h20, 1'b1, 16'h4000));
        vecs.push_back(mkvec(10'h005, 6'h3e, 1'b1, 16'hFFF6));
        vecs.push_back(mkvec(10'h3ff, 6'h3f, 1'b0, 16'hFBC1));
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sm, $sformatf("vec%0d", i), vecs[i].exp);
        end

        // start pulsed while CALC is running must be ignored
        @(negedge clk);
        start = 1'b1; in1 = 10'h3ff; in2 = 6'h3f;
`ifdef SEQ_MULT_SIGNED_EN
        signed_mode = 1'b0;
`endif
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1; in1 = 10'h155; in2 = 6'h2a;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) begin
                dones++;
                check("ignored_start_done_out", {16'd0, out}, 32'hFBC1);
            end
        end
        check("ignored_start_done_count", dones, 1);
        check("ignored_start_held_out", {15'd0, busy, out}, 32'hFBC1);
        run_op(10'h03f, 6'h1f, 1'b0, "after_ignored", 16'h07A1);

        // reset asserted mid-operation aborts it
        @(negedge clk);
        start = 1'b1; in1 = 10'h3ff; in2 = 6'h3f;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midreset_async", {14'd0, busy, done, out}, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        dones = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midreset_no_done", dones, 0);
        check("midreset_out", {15'd0, busy, out}, 32'h0);
        run_op(10'h03f, 6'h1f, 1'b0, "after_reset", 16'h07A1);

        // random operands against the reference model
        for (int i = 0; i < 20; i++) begin
            ra = 10'($urandom);
            rb = 6'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
            rsm = 1'($urandom);
`else
            rsm = 1'b0;
`endif
            run_op(ra, rb, rsm, $sformatf("rand%0d", i), model(ra, rb, rsm));
        end

        // 8x8 instance: max operands, latency B_W+1 = 9 edges
        @(negedge clk);
        s8_start = 1'b1; s8_in1 = 8'hff; s8_in2 = 8'hff;
        @(posedge clk);
        @(negedge clk);
        s8_start = 1'b0;
        n = 0;
        while (!s8_done && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("w8_latency", n + 1, 9);
        check("w8_out", {16'd0, s8_out}, 32'hFE01);
        @(negedge clk);
        check("w8_end_done_busy", {30'd0, s8_done, s8_busy}, 32'h0);

        // 8x8 back-to-back starts at the minimum 10-cycle spacing
        dones = 0;
        for (int k = 0; k < 4; k++) begin
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            e8 = 16'(int'(a8) * int'(b8));
            s8_start = 1'b1; s8_in1 = a8; s8_in2 = b8;
            for (int c = 0; c < 10; c++) begin
                @(posedge clk);
                @(negedge clk);
                if (c == 0) s8_start = 1'b0;
                if (s8_done) begin
                    dones++;
                    check($sformatf("b2b%0d_out", k), {16'd0, s8_out}, {16'd0, e8});
                    check($sformatf("b2b%0d_phase", k), c, 8);
                end
            end
        end
        check("b2b_done_count", dones, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
